// File: rtl/banked_mem_responder.sv
// Four-bank interleaved 16-bit word memory responder with per-bank busy timers
// and a two-cycle read pipeline, serving cache write-back and line-fill requests.
module banked_mem_responder #(
   parameter int unsigned MEM_WORDS = 32768,
   parameter int unsigned BANK_BUSY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        wr,
   input  logic        rd,
   output logic [15:0] DataOut,
   output logic        data_valid,
   output logic        stall,
   output logic [3:0]  busy,
   output logic        err
);

   localparam int unsigned IdxW = $clog2(MEM_WORDS);
   localparam int unsigned RowW = IdxW - 2;
   localparam logic [3:0] BusyLoad = 4'(BANK_BUSY - 1);

   logic [1:0]      bank;
   logic [IdxW-1:0] idx;
   logic            req;
   logic            accept;

   logic [15:0] mem_q [MEM_WORDS];
   logic [15:0] rd_data_q;
   logic        rd_vld_q;
   logic        dv_q;
   logic [15:0] dout_q;
   logic [3:0]  cnt_q [4];
   logic [3:0]  cnt_d [4];

   // Row bits above the array size are dropped, so the row index wraps.
   assign bank   = Addr[2:1];
   assign idx    = {Addr[3 +: RowW], bank};
   assign req    = wr | rd;
   assign err    = (wr & rd) | (req & Addr[0]);
   assign stall  = req & ~err & busy[bank];
   assign accept = req & ~err & ~stall;

   assign DataOut    = dout_q;
   assign data_valid = dv_q;

   always_comb begin
      busy = '0;
      for (int b = 0; b < 4; b++) begin
         busy[b] = (cnt_q[b] != 4'd0);
      end
   end

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         cnt_d[b] = (cnt_q[b] != 4'd0) ? cnt_q[b] - 4'd1 : cnt_q[b];
         if (accept && (bank == 2'(b))) begin
            cnt_d[b] = BusyLoad;
         end
      end
   end

   // Storage is deliberately not reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (accept && wr && !rst) begin
         mem_q[idx] <= DataIn;
      end
      if (accept && rd) begin
         rd_data_q <= mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
         dv_q     <= 1'b0;
         dout_q   <= '0;
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         rd_vld_q <= accept & rd;
         dv_q     <= rd_vld_q;
         dout_q   <= rd_vld_q ? rd_data_q : '0;
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench: per-cycle vector table for the default instance, plus a short
// hand sequence for a single-cycle-busy, small-memory instance.
module tb_banked_mem_responder;

   logic        clk;
   logic        rst, wr, rd;
   logic [15:0] addr, din;
   logic [15:0] dout;
   logic        dv, stall, err;
   logic [3:0]  busy;

   logic        rst1, wr1, rd1;
   logic [15:0] addr1, din1;
   logic [15:0] dout1;
   logic        dv1, stall1, err1;
   logic [3:0]  busy1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        wr;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
      logic        dv;
      logic [15:0] dout;
      logic        stall;
      logic        err;
      logic [3:0]  busy;
   } vec_t;

   vec_t vecs[$];

   banked_mem_responder #(.MEM_WORDS(32768), .BANK_BUSY(4)) u_dut (
      .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .wr(wr), .rd(rd),
      .DataOut(dout), .data_valid(dv), .stall(stall), .busy(busy), .err(err)
   );

   banked_mem_responder #(.MEM_WORDS(64), .BANK_BUSY(1)) u_dut1 (
      .clk(clk), .rst(rst1), .Addr(addr1), .DataIn(din1), .wr(wr1), .rd(rd1),
      .DataOut(dout1), .data_valid(dv1), .stall(stall1), .busy(busy1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic v(input logic r, input logic w, input logic rr, input logic [15:0] a,
                    input logic [15:0] d, input logic edv, input logic [15:0] edo,
                    input logic est, input logic eer, input logic [3:0] ebu);
      vec_t t;
      t.rst = r; t.wr = w; t.rd = rr; t.addr = a; t.din = d;
      t.dv = edv; t.dout = edo; t.stall = est; t.err = eer; t.busy = ebu;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int row, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, row, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
      rst1 = 1'b1; wr1 = 1'b0; rd1 = 1'b0; addr1 = '0; din1 = '0;

      //  rst wr rd addr      din       dv dout     st er busy
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r0 reset state
      v(0, 1, 0, 16'h0010, 16'hBEEF, 0, 16'h0000, 0, 0, 4'b0000); // r1 T
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 1, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r5 T+4
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 0, 4'b0001); // r7 T+6
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 1, 0, 16'h0100, 16'h1111, 0, 16'h0000, 0, 0, 4'b0000); // r9 burst
      v(0, 1, 0, 16'h0102, 16'h2222, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 1, 0, 16'h0104, 16'h3333, 0, 16'h0000, 0, 0, 4'b0011);
      v(0, 1, 0, 16'h0106, 16'h4444, 0, 16'h0000, 0, 0, 4'b0111);
      v(0, 0, 1, 16'h0100, 16'h0000, 0, 16'h0000, 0, 0, 4'b1110); // r13
      v(0, 0, 1, 16'h0102, 16'h0000, 0, 16'h0000, 0, 0, 4'b1101);
      v(0, 0, 1, 16'h0104, 16'h0000, 1, 16'h1111, 0, 0, 4'b1011);
      v(0, 0, 1, 16'h0106, 16'h0000, 1, 16'h2222, 0, 0, 4'b0111);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h3333, 0, 0, 4'b1110);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h4444, 0, 0, 4'b1100);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b1000);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000);
      v(0, 1, 0, 16'h0000, 16'h0A0A, 0, 16'h0000, 0, 0, 4'b0000); // r21 stall test
      v(0, 1, 0, 16'h0008, 16'hC0DE, 0, 16'h0000, 1, 0, 4'b0001);
      v(0, 1, 0, 16'h0008, 16'hC0DE, 0, 16'h0000, 1, 0, 4'b0001);
      v(0, 1, 0, 16'h0008, 16'hC0DE, 0, 16'h0000, 1, 0, 4'b0001);
      v(0, 1, 0, 16'h0008, 16'hC0DE, 0, 16'h0000, 0, 0, 4'b0000); // r25 accepted
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 1, 16'h0008, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r29
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hC0DE, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r33
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0A0A, 0, 0, 4'b0001);
      v(0, 1, 1, 16'h0010, 16'hDEAD, 0, 16'h0000, 0, 1, 4'b0001); // r36 wr&rd
      v(0, 0, 1, 16'h0003, 16'h0000, 0, 16'h0000, 0, 1, 4'b0000); // r37 odd read
      v(0, 1, 0, 16'h0011, 16'hDEAD, 0, 16'h0000, 0, 1, 4'b0000); // r38 odd write
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000);
      v(0, 0, 1, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r40
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 1, 0, 16'h0020, 16'h5A5A, 0, 16'h0000, 0, 0, 4'b0000); // r44
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r48 T
      v(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001); // r49 rst
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000); // r50 killed
      v(0, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h5A5A, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(1, 1, 0, 16'h0020, 16'hFFFF, 0, 16'h0000, 0, 0, 4'b0000); // r55 wr under rst
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000);
      v(0, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000, 0, 0, 4'b0000);
      v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'b0001);
      v(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h5A5A, 0, 0, 4'b0001);

      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; wr = vecs[i].wr; rd = vecs[i].rd;
         addr = vecs[i].addr; din = vecs[i].din;
         @(negedge clk);
         chk("data_valid", i, {15'd0, dv}, {15'd0, vecs[i].dv});
         chk("DataOut", i, dout, vecs[i].dout);
         chk("stall", i, {15'd0, stall}, {15'd0, vecs[i].stall});
         chk("err", i, {15'd0, err}, {15'd0, vecs[i].err});
         chk("busy", i, {12'd0, busy}, {12'd0, vecs[i].busy});
         step();
      end
      rst = 1'b0; wr = 1'b0; rd = 1'b0;

      // BANK_BUSY=1, 64 words: 0x0080 wraps onto row 0, then five back-to-back reads.
      rst1 = 1'b0;
      for (int c = 0; c < 9; c++) begin
         logic exp_dv;
         wr1 = (c == 0);
         rd1 = (c >= 1) && (c <= 5);
         addr1 = (c == 0) ? 16'h0080 : 16'h0000;
         din1 = 16'h7777;
         exp_dv = (c >= 3) && (c <= 7);
         @(negedge clk);
         chk("bb1 stall", c, {15'd0, stall1}, 16'h0000);
         chk("bb1 busy", c, {12'd0, busy1}, 16'h0000);
         chk("bb1 data_valid", c, {15'd0, dv1}, {15'd0, exp_dv});
         chk("bb1 DataOut", c, dout1, exp_dv ? 16'h7777 : 16'h0000);
         step();
      end
      wr1 = 1'b0; rd1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/banked_mem_responder.md
Name: banked_mem_responder

Overview:
- Memory-side responder for the cache-to-memory interface. It accepts word read and write requests that the cache controller issues during victim write-back and line fill.
- Implements four interleaved 16-bit banks, each with a fixed per-bank busy time, and a fixed two-cycle read latency.
- Signals back-pressure through stall and busy so the requester can schedule bursts.
- Sits between the cache controller and the backing storage array.

Parameters:
- MEM_WORDS, 32768: total 16-bit words; must be 4 x a power of two.
- BANK_BUSY, 4: cycles a bank is occupied per accepted access, counting the accept cycle; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- Addr  input  16  byte address; Addr[2:1] = bank, Addr[15:3] = row within bank, Addr[0] must be 0
- DataIn  input  16  write data
- wr  input  1  write request
- rd  input  1  read request
- DataOut  output  16  read data; valid only when data_valid=1, otherwise 16'h0000
- data_valid  output  1  DataOut carries the response to a read accepted two cycles earlier
- stall  output  1  combinational; current request targets a busy bank and is not accepted
- busy  output  4  per-bank occupied flags, one bit per bank
- err  output  1  combinational; illegal request, which is dropped

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: DataOut=0, data_valid=0, busy=4'b0000, read pipeline cleared.
  - Memory array is not reset; contents persist across rst.
- err = (wr & rd) | ((wr | rd) & Addr[0]).
- stall = (wr | rd) & ~err & busy[Addr[2:1]].
- accept = (wr | rd) & ~err & ~stall.
  - A rejected request has no side effects. The requester must hold it until it is accepted.
- Write accepted in cycle T: the array is updated at the clk edge ending T.
- Read accepted in cycle T:
  - The array is sampled at the edge ending T and carried through one pipeline register.
  - data_valid=1 and DataOut=data during cycle T+2 only.
  - Back-to-back reads to different banks give one valid word per cycle.
- Per-bank counter:
  - On accept, the bank's counter loads BANK_BUSY-1.
  - Each cycle, a nonzero counter decrements by 1.
  - busy[b] = (counter_b != 0).
  - The bank is therefore busy in cycles T+1..T+BANK_BUSY-1 and free at T+BANK_BUSY.
  - With BANK_BUSY=1, busy never asserts.
- Ordering: a write and a later read to the same address are separated by at least BANK_BUSY cycles, so the read returns the new data.
  - Read-during-write to the same word in one cycle cannot occur, because only one request is accepted per cycle.
- Burst pattern: byte offsets 0,2,4,6 of a line map to banks 0,1,2,3 and issue on consecutive cycles without stall.
  - With BANK_BUSY<=4, a next burst to the same line can start at cycle T+4.
- Reset mid-operation:
  - rst has priority over accept.
  - It kills any in-flight read, so no data_valid appears afterwards.
  - It clears all busy counters.
  - A write accepted in the same cycle rst is high is not performed.
- Address wrap: row index is Addr[15:3] modulo MEM_WORDS/4. Higher bits are ignored when MEM_WORDS < 32768.
- Structure: no state machine beyond the counters and the 2-stage read pipeline; data_valid is a registered shift of (accept & rd).

Test Plan:
1. After rst, write 16'hBEEF to 16'h0010 in cycle T.
   - busy[0] must be 1 in T+1..T+3 and 0 in T+4.
   - A read of 16'h0010 at T+4 must give data_valid=1, DataOut=16'hBEEF in T+6.
2. Burst writes to 0x0100, 0x0102, 0x0104, 0x0106 carrying 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
   - stall must stay 0 throughout.
   - Reads of the same four addresses starting 4 cycles later must return the four words in four consecutive data_valid cycles, in order.
3. Write 0x0000 in T, then hold a write to 0x0008 (bank 0).
   - stall=1 in T+1..T+3; the write is accepted in T+4.
   - A later read of 0x0008 returns the new data.
4. wr=rd=1, or rd with Addr=16'h0003.
   - err=1 and stall=0.
   - No data_valid follows, busy is unchanged, and memory is unchanged (verified by a later read).
5. Read 0x0020 (prior value 0x5A5A) accepted in T, with rst=1 in T+1.
   - data_valid=0 in T+2 and busy=0.
   - A fresh read of 0x0020 returns 0x5A5A.
6. Instance with BANK_BUSY=1: reads to 0x0000 every cycle for 5 cycles.
   - stall never asserts.
   - data_valid is 1 for 5 consecutive cycles, starting 2 cycles after the first read.
